// File: rtl/cpz_timer_if.sv
// cpz_timer_if -- CP0 register access bus (mfc0 / mtc0).
//   addr    : CP0 register number
//   we      : mtc0 write enable
//   wd      : mtc0 write data
//   DataOut : mfc0 read data (combinational from the CP0 block)
// Modports: master = pipeline side, slave = CP0 block side.
interface cpz_timer_if;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] DataOut;

  modport master (output addr, output we, output wd, input DataOut);
  modport slave  (input addr, input we, input wd, output DataOut);
endinterface

// File: rtl/cpz_timer.sv
// cpz_timer -- MIPS-style coprocessor 0 with exception control and an
// optional Count/Compare timer.
// Ports:
//   clk        : single clock, all state changes on posedge
//   reset      : synchronous active-low reset
//   bus        : cpz_timer_if.slave (addr, we, wd, DataOut)
//   PC4M       : PC+4 of the M-stage instruction
//   ExcBD      : M-stage instruction sits in a branch delay slot
//   ExcCodeM   : synchronous exception code from M (0 = none)
//   BadVAddrM  : faulting address for AdEL/AdES
//   ERET       : eret in M
//   HWInt      : level-sensitive external interrupt lines
//   ExcHandle  : redirect to handler this cycle (combinational)
//   EPC        : exception return address
//   TimerIrq   : timer interrupt pending flag
// Configuration: define CPZ_TIMER_EN to build the Count/Compare timer.
// Without it, registers 9 and 11 read 0, ignore writes, and TimerIrq is 0.
module cpz_timer #(
  parameter int          NUM_HWINT = 5,
  parameter logic [31:0] PRID_VAL  = 32'h0001_BF52
) (
  input  logic                 clk,
  input  logic                 reset,
  cpz_timer_if.slave           bus,
  input  logic [31:0]          PC4M,
  input  logic                 ExcBD,
  input  logic [4:0]           ExcCodeM,
  input  logic [31:0]          BadVAddrM,
  input  logic                 ERET,
  input  logic [NUM_HWINT-1:0] HWInt,
  output logic                 ExcHandle,
  output logic [31:0]          EPC,
  output logic                 TimerIrq
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // Architectural state
  logic [31:0]          sr;
  logic                 causeBd;
  logic [1:0]           causeSw;
  logic [NUM_HWINT-1:0] causeHw;
  logic [4:0]           causeExc;
  logic [31:0]          epcReg;
  logic [31:0]          badVAddr;

  // Derived signals
  logic [4:0]  hwIpPad;
  logic [7:0]  ipVec;
  logic        intPending;
  logic        mtc0Ok;
  logic        timerBit;
  logic [31:0] countRd;
  logic [31:0] compareRd;
  logic [31:0] causeView;
  logic [31:0] epcNext;

  // Pad the registered hardware lines out to the five IP slots [14:10]
  always_comb begin
    hwIpPad = 5'd0;
    hwIpPad[NUM_HWINT-1:0] = causeHw;
  end

  // Interrupt/exception decision and derived values
  always_comb begin
    ipVec      = {timerBit, hwIpPad, causeSw};
    intPending = sr[0] & (|(ipVec & sr[15:8]));
    ExcHandle  = ~sr[1] & ((ExcCodeM != 5'd0) | intPending);
    // mtc0 loses to both an exception and an eret in the same cycle
    mtc0Ok     = bus.we & ~ExcHandle & ~ERET;
    causeView  = {causeBd, 15'd0, ipVec, 1'b0, causeExc, 2'b00};
    // Word-align PC+4, then step back to the faulting (or branch) instruction
    epcNext    = (PC4M & 32'hFFFF_FFFC) - (ExcBD ? 32'd8 : 32'd4);
  end

  // mfc0 read mux
  always_comb begin
    case (bus.addr)
      REG_BADVADDR: bus.DataOut = badVAddr;
      REG_COUNT:    bus.DataOut = countRd;
      REG_COMPARE:  bus.DataOut = compareRd;
      REG_SR:       bus.DataOut = sr;
      REG_CAUSE:    bus.DataOut = causeView;
      REG_EPC:      bus.DataOut = epcReg;
      REG_PRID:     bus.DataOut = PRID_VAL;
      default:      bus.DataOut = 32'd0;
    endcase
  end

  // SR / Cause / EPC / BadVAddr update: exception > eret > mtc0
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr       <= 32'h0000_FF11;
      causeBd  <= 1'b0;
      causeSw  <= 2'b00;
      causeHw  <= '0;
      causeExc <= 5'd0;
      epcReg   <= 32'd0;
      badVAddr <= 32'd0;
    end else begin
      causeHw <= HWInt;
      if (ExcHandle) begin
        sr[1]    <= 1'b1;
        causeBd  <= ExcBD;
        causeExc <= intPending ? 5'd0 : ExcCodeM;
        epcReg   <= epcNext;
        if (!intPending && ((ExcCodeM == 5'd4) || (ExcCodeM == 5'd5))) begin
          badVAddr <= BadVAddrM;
        end
      end else if (ERET) begin
        sr[1] <= 1'b0;
      end else if (mtc0Ok) begin
        case (bus.addr)
          REG_SR:    sr      <= bus.wd;
          REG_CAUSE: causeSw <= bus.wd[9:8];
          REG_EPC:   epcReg  <= bus.wd;
          default:   ;
        endcase
      end
    end
  end

  assign EPC = epcReg;

`ifdef CPZ_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        timerIrqR;

  // Free-running Count, Compare register and sticky match flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= 32'd0;
      compare   <= 32'd0;
      timerIrqR <= 1'b0;
    end else begin
      if (mtc0Ok && (bus.addr == REG_COUNT)) begin
        count <= bus.wd;
      end else begin
        count <= count + 32'd1;
      end
      // A Compare write acknowledges the interrupt, even against a match
      if (mtc0Ok && (bus.addr == REG_COMPARE)) begin
        compare   <= bus.wd;
        timerIrqR <= 1'b0;
      end else if (count == compare) begin
        timerIrqR <= 1'b1;
      end
    end
  end

  assign timerBit  = timerIrqR;
  assign countRd   = count;
  assign compareRd = compare;
`else
  assign timerBit  = 1'b0;
  assign countRd   = 32'd0;
  assign compareRd = 32'd0;
`endif

  assign TimerIrq = timerBit;

endmodule
